// File: rtl/dcsformer_pipe.sv
// Streaming DCSformer attention core: Gram matrix H = X*X^T, optional row-average
// thresholding (enabled by defining DCSF_RAT_EN), then H*w for NUM_VEC weight vectors.
module dcsformer_pipe #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 16,
  parameter int unsigned DW      = 8,
  parameter int unsigned NUM_VEC = 1,
  localparam int unsigned HW     = 2 * DW + $clog2(COLS),
  localparam int unsigned OW     = HW + DW + $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          i_ready,
  input  logic          w_valid,
  input  logic [DW-1:0] w_data,
  output logic          w_ready,
  output logic          o_valid,
  output logic [OW-1:0] o_data,
  output logic          o_last,
  input  logic          o_ready
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned VW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int unsigned SW = HW + RW;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_THRESH = 2'd1;
  localparam logic [1:0] S_WLOAD  = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [DW-1:0] xbuf     [ROWS][COLS];
  logic [DW-1:0] xbuf_nxt [ROWS][COLS];
  logic [HW-1:0] h        [ROWS][ROWS];
  logic [HW-1:0] h_nxt    [ROWS][ROWS];
  logic [HW-1:0] hthr     [ROWS][ROWS];
  logic [OW-1:0] acc      [ROWS];
  logic [OW-1:0] acc_nxt  [ROWS];
  logic [RW-1:0] row, row_nxt, wcnt, wcnt_nxt, ocnt, ocnt_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [VW-1:0] vcnt, vcnt_nxt;
  logic [OW-1:0] o_data_nxt;
  logic          o_last_nxt;
  logic          x_fire, w_fire, o_fire;

  assign x_fire = i_valid & i_ready;
  assign w_fire = w_valid & w_ready;
  assign o_fire = o_valid & o_ready;

  function automatic logic [2*DW-1:0] mul_x(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  endfunction

  function automatic logic [HW+DW-1:0] mul_w(input logic [HW-1:0] a, input logic [DW-1:0] b);
    return {{DW{1'b0}}, a} * {{HW{1'b0}}, b};
  endfunction

  // Symmetric view of the lower-triangle accumulator, optionally row-average thresholded
  always_comb begin : thresh_comb
`ifdef DCSF_RAT_EN
    logic [SW-1:0] rsum;
    logic [SW-1:0] avg;
`endif
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < ROWS; j++) begin
        hthr[i][j] = (j <= i) ? h[i][j] : h[j][i];
      end
`ifdef DCSF_RAT_EN
      rsum = '0;
      for (int j = 0; j < ROWS; j++) begin
        rsum = rsum + SW'(hthr[i][j]);
      end
      avg = rsum >> RW;
      for (int j = 0; j < ROWS; j++) begin
        if (SW'(hthr[i][j]) < avg) hthr[i][j] = '0;
      end
`endif
    end
  end

  always_comb begin : next_comb
    state_nxt  = state;
    xbuf_nxt   = xbuf;
    h_nxt      = h;
    acc_nxt    = acc;
    row_nxt    = row;
    col_nxt    = col;
    wcnt_nxt   = wcnt;
    ocnt_nxt   = ocnt;
    vcnt_nxt   = vcnt;
    o_data_nxt = o_data;
    o_last_nxt = o_last;
    case (state)
      S_LOAD: begin
        if (x_fire) begin
          xbuf_nxt[row][col] = i_data;
          for (int k = 0; k < ROWS; k++) begin
            if (RW'(k) < row)
              h_nxt[row][k] = h[row][k] + HW'(mul_x(xbuf[k][col], i_data));
            else if (RW'(k) == row)
              h_nxt[row][k] = h[row][k] + HW'(mul_x(i_data, i_data));
          end
          if (col == CW'(COLS - 1)) begin
            col_nxt = '0;
            if (row == RW'(ROWS - 1)) begin
              row_nxt   = '0;
              state_nxt = S_THRESH;
            end else begin
              row_nxt = row + 1'b1;
            end
          end else begin
            col_nxt = col + 1'b1;
          end
        end
      end
      S_THRESH: begin
        h_nxt     = hthr;
        state_nxt = S_WLOAD;
      end
      S_WLOAD: begin
        if (w_fire) begin
          for (int i = 0; i < ROWS; i++) begin
            acc_nxt[i] = acc[i] + OW'(mul_w(h[i][wcnt], w_data));
          end
          if (wcnt == RW'(ROWS - 1)) begin
            wcnt_nxt   = '0;
            ocnt_nxt   = '0;
            o_data_nxt = acc_nxt[0];
            o_last_nxt = 1'b0;
            state_nxt  = S_OUT;
          end else begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end
      end
      default: begin
        if (o_fire) begin
          if (ocnt == RW'(ROWS - 1)) begin
            ocnt_nxt   = '0;
            o_last_nxt = 1'b0;
            acc_nxt    = '{default: '0};
            if (vcnt == VW'(NUM_VEC - 1)) begin
              vcnt_nxt  = '0;
              h_nxt     = '{default: '0};
              state_nxt = S_LOAD;
            end else begin
              vcnt_nxt  = vcnt + 1'b1;
              state_nxt = S_WLOAD;
            end
          end else begin
            ocnt_nxt   = ocnt + 1'b1;
            o_data_nxt = acc[ocnt_nxt];
            o_last_nxt = (ocnt_nxt == RW'(ROWS - 1));
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_LOAD;
      xbuf    <= '{default: '0};
      h       <= '{default: '0};
      acc     <= '{default: '0};
      row     <= '0;
      col     <= '0;
      wcnt    <= '0;
      ocnt    <= '0;
      vcnt    <= '0;
      i_ready <= 1'b0;
      w_ready <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= '0;
    end else begin
      state   <= state_nxt;
      xbuf    <= xbuf_nxt;
      h       <= h_nxt;
      acc     <= acc_nxt;
      row     <= row_nxt;
      col     <= col_nxt;
      wcnt    <= wcnt_nxt;
      ocnt    <= ocnt_nxt;
      vcnt    <= vcnt_nxt;
      i_ready <= (state_nxt == S_LOAD);
      w_ready <= (state_nxt == S_WLOAD);
      o_valid <= (state_nxt == S_OUT);
      o_last  <= o_last_nxt;
      o_data  <= o_data_nxt;
    end
  end

endmodule

// File: tb/tb_dcsformer_pipe.sv
// Directed scoreboard bench for dcsformer_pipe (NUM_VEC=2); expectations follow DCSF_RAT_EN.
module tb_dcsformer_pipe;
  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 16;
  localparam int unsigned DW   = 8;
  localparam int unsigned NV   = 2;
  localparam int unsigned OW   = 31;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_ready;
  logic          w_valid = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          w_ready;
  logic          o_valid;
  logic [OW-1:0] o_data;
  logic          o_last;
  logic          o_ready = 1'b0;

  always #5 clk = ~clk;

  dcsformer_pipe #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .NUM_VEC(NV)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_ready(o_ready)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] xm [ROWS][COLS];
  logic [DW-1:0] wv [ROWS];
  logic [63:0]   sb [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_x(input logic [DW-1:0] v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) xm[r][c] = v;
  endtask

  task automatic push_const(input logic [63:0] v);
    for (int i = 0; i < ROWS; i++) sb.push_back(v);
  endtask

  // Reference: direct X*X^T, optional row-average threshold, then H*w
  task automatic model_push();
    logic [63:0] hm [ROWS][ROWS];
    logic [63:0] s;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < ROWS; j++) begin
        hm[i][j] = '0;
        for (int c = 0; c < COLS; c++)
          hm[i][j] = hm[i][j] + 64'(xm[i][c]) * 64'(xm[j][c]);
      end
`ifdef DCSF_RAT_EN
    for (int i = 0; i < ROWS; i++) begin
      s = '0;
      for (int j = 0; j < ROWS; j++) s = s + hm[i][j];
      s = s / ROWS;
      for (int j = 0; j < ROWS; j++) if (hm[i][j] < s) hm[i][j] = '0;
    end
`endif
    for (int i = 0; i < ROWS; i++) begin
      s = '0;
      for (int j = 0; j < ROWS; j++) s = s + hm[i][j] * 64'(wv[j]);
      sb.push_back(s);
    end
  endtask

  task automatic drive_frame(input int n, input bit gaps);
    int idx = 0;
    int guard = 0;
    bit fire;
    while (idx < n && guard < 4000) begin
      @(negedge clk);
      guard++;
      i_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_data  = xm[idx / COLS][idx % COLS];
      fire    = i_valid && i_ready;
      @(posedge clk);
      if (fire) idx++;
    end
    @(negedge clk);
    i_valid = 1'b0;
    if (idx < n) chk("frame_timeout", 64'(idx), 64'(n));
    if (n == ROWS * COLS) begin
      chk("thresh_i_ready", 64'(i_ready), 64'd0);
      chk("thresh_w_ready", 64'(w_ready), 64'd0);
      @(negedge clk);
      chk("wload_w_ready", 64'(w_ready), 64'd1);
    end
  endtask

  task automatic drive_weights(input bit gaps);
    int idx = 0;
    int guard = 0;
    bit fire;
    while (idx < ROWS && guard < 1000) begin
      @(negedge clk);
      guard++;
      w_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      w_data  = wv[idx];
      fire    = w_valid && w_ready;
      @(posedge clk);
      if (fire) idx++;
    end
    @(negedge clk);
    w_valid = 1'b0;
    if (idx < ROWS) chk("weight_timeout", 64'(idx), 64'(ROWS));
    chk("o_valid_latency", 64'(o_valid), 64'd1);
  endtask

  task automatic collect_vec(input bit bp, input bit last_vec);
    int k = 0;
    int guard = 0;
    int stall = 0;
    logic [63:0] e;
    while (k < ROWS && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (bp && k == 2 && stall < 3) begin
        o_ready = 1'b0;
        chk("bp_valid", 64'(o_valid), 64'd1);
        chk("bp_hold_data", 64'(o_data), sb[0]);
        chk("bp_hold_last", 64'(o_last), 64'd0);
        stall++;
        continue;
      end
      o_ready = 1'b1;
      if (o_valid) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("y", 64'(o_data), e);
          chk("o_last", 64'(o_last), 64'(k == ROWS - 1));
        end
        k++;
      end
    end
    if (k < ROWS) chk("out_timeout", 64'(k), 64'(ROWS));
    @(negedge clk);
    o_ready = 1'b0;
    chk("post_o_valid", 64'(o_valid), 64'd0);
    if (last_vec) chk("post_i_ready", 64'(i_ready), 64'd1);
    else          chk("post_w_ready", 64'(w_ready), 64'd1);
  endtask

  task automatic set_w_const(input logic [DW-1:0] v);
    for (int j = 0; j < ROWS; j++) wv[j] = v;
  endtask

  initial begin
    // Reset condition
    repeat (2) @(negedge clk);
    chk("rst_i_ready", 64'(i_ready), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_last",  64'(o_last),  64'd0);
    chk("rst_o_data",  64'(o_data),  64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("i_ready_after_rst", 64'(i_ready), 64'd1);

    // All ones; vector 1 = ones with backpressure, vector 2 = 1..8
    fill_x(8'd1);
    drive_frame(ROWS * COLS, 1'b0);
    set_w_const(8'd1);
    push_const(64'd128);
    drive_weights(1'b0);
    collect_vec(1'b1, 1'b0);
    for (int j = 0; j < ROWS; j++) wv[j] = DW'(j + 1);
    push_const(64'd576);
    drive_weights(1'b0);
    collect_vec(1'b0, 1'b1);

    // Row-average thresholding case
    fill_x(8'd0);
    for (int c = 0; c < COLS; c++) begin
      xm[0][c] = 8'd4;
      xm[1][c] = 8'd1;
    end
    xm[2][0] = 8'd1;
    drive_frame(ROWS * COLS, 1'b1);
    set_w_const(8'd1);
    for (int v = 0; v < 2; v++) begin
`ifdef DCSF_RAT_EN
      sb.push_back(64'd320); sb.push_back(64'd80);
`else
      sb.push_back(64'd324); sb.push_back(64'd81);
`endif
      sb.push_back(64'd6);
      for (int i = 3; i < ROWS; i++) sb.push_back(64'd0);
      drive_weights(1'b1);
      collect_vec(1'b0, v == 1);
    end

    // Maximum values
    fill_x(8'd255);
    drive_frame(ROWS * COLS, 1'b0);
    set_w_const(8'd255);
    for (int v = 0; v < 2; v++) begin
      push_const(64'd2122416000);
      drive_weights(1'b0);
      collect_vec(1'b0, v == 1);
    end

    // Abort after 50 activations, then a clean all-ones frame
    fill_x(8'd7);
    drive_frame(50, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_i_ready", 64'(i_ready), 64'd0);
    chk("abort_o_valid", 64'(o_valid), 64'd0);
    rst = 1'b0;
    fill_x(8'd1);
    drive_frame(ROWS * COLS, 1'b0);
    set_w_const(8'd1);
    for (int v = 0; v < 2; v++) begin
      push_const(64'd128);
      drive_weights(1'b0);
      collect_vec(1'b0, v == 1);
    end

    // Random matrix and weights against the reference model
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) xm[r][c] = DW'($urandom_range(0, 255));
    drive_frame(ROWS * COLS, 1'b1);
    for (int v = 0; v < 2; v++) begin
      for (int j = 0; j < ROWS; j++) wv[j] = DW'($urandom_range(0, 255));
      model_push();
      drive_weights(1'b1);
      collect_vec(1'b0, v == 1);
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
